// File: rtl/font_rom_arbiter.sv
// Two-requester arbiter in front of a shared synchronous font ROM.
// Requester 0 wins by default. Requester 1 is force-granted after MAX_WAIT
// consecutive denied cycles. Read data returns one cycle after the grant.
module font_rom_arbiter #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic [5:0] addr0,
  input  logic       req1,
  input  logic [5:0] addr1,
  output logic [5:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic       gnt0,
  output logic       gnt1,
  output logic       valid0,
  output logic       valid1,
  output logic [7:0] data0,
  output logic [7:0] data1,
  output logic       forced
);

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_0    = 2'd1,
    TAG_1    = 2'd2
  } tag_e;

  tag_e          tag_q, tag_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data0_q, data0_d;
  logic [DW-1:0] data1_q, data1_d;
  logic          forced_q, forced_d;
  logic          force_c;

  // Grant decision: starvation override first, then fixed priority; nothing while in reset.
  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    force_c = 1'b0;
    if (!reset) begin
      if (req1 && (wait_cnt_q == CW'(MAX_WAIT))) begin
        gnt1    = 1'b1;
        force_c = 1'b1;
      end else if (req0) begin
        gnt0 = 1'b1;
      end else if (req1) begin
        gnt1 = 1'b1;
      end
    end
  end

  // ROM address mux, owner tag, starvation counter and next register values.
  always_comb begin
    rom_addr   = addr_q;
    tag_d      = TAG_NONE;
    wait_cnt_d = '0;
    forced_d   = force_c;
    if (gnt0) begin
      rom_addr = addr0;
      tag_d    = TAG_0;
    end else if (gnt1) begin
      rom_addr = addr1;
      tag_d    = TAG_1;
    end
    addr_d = rom_addr;
    if (req1 && !gnt1) begin
      wait_cnt_d = (wait_cnt_q == CW'(MAX_WAIT)) ? wait_cnt_q : wait_cnt_q + CW'(1);
    end
  end

  // Return path: the tag from last cycle steers the ROM word to its owner.
  always_comb begin
    valid0  = (tag_q == TAG_0);
    valid1  = (tag_q == TAG_1);
    data0   = valid0 ? rom_data : data0_q;
    data1   = valid1 ? rom_data : data1_q;
    data0_d = data0;
    data1_d = data1;
    forced  = forced_q;
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_q      <= TAG_NONE;
      wait_cnt_q <= '0;
      addr_q     <= '0;
      data0_q    <= '0;
      data1_q    <= '0;
      forced_q   <= 1'b0;
    end else begin
      tag_q      <= tag_d;
      wait_cnt_q <= wait_cnt_d;
      addr_q     <= addr_d;
      data0_q    <= data0_d;
      data1_q    <= data1_d;
      forced_q   <= forced_d;
    end
  end

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Scoreboard bench for font_rom_arbiter: a driver applies stimulus and
// predicts grants; a monitor checks returned words against queued predictions.
module tb_font_rom_arbiter;

  localparam int unsigned MAX_WAIT = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, req1;
  logic [5:0] addr0, addr1;
  logic [5:0] rom_addr;
  logic [7:0] rom_data;
  logic       gnt0, gnt1, valid0, valid1, forced;
  logic [7:0] data0, data1;

  font_rom_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .addr0(addr0), .req1(req1), .addr1(addr1),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .gnt0(gnt0), .gnt1(gnt1), .valid0(valid0), .valid1(valid1),
    .data0(data0), .data1(data1), .forced(forced)
  );

  always #5 clk = ~clk;

  // Synchronous font ROM model
  logic [7:0] rom_mem [64];
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         due;
    bit         owner;
    logic [5:0] addr;
  } exp_t;
  exp_t sbq[$];

  // Reference state
  int         denied;
  bit         prev_force;
  logic [5:0] last_addr;
  logic [7:0] last_d0, last_d1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_cnt);
    end
  endtask

  task automatic model_reset();
    sbq.delete();
    denied     = 0;
    prev_force = 1'b0;
    last_addr  = '0;
    last_d0    = '0;
    last_d1    = '0;
  endtask

  // One clock cycle of stimulus plus grant-side prediction and checks
  task automatic cycle(input logic r0, input logic [5:0] a0, input logic r1, input logic [5:0] a1);
    bit         e0, e1, ef;
    logic [5:0] ea;
    exp_t       item;
    @(posedge clk);
    #1;
    req0 = r0; addr0 = a0; req1 = r1; addr1 = a1;
    #3;
    ef = r1 && (denied == int'(MAX_WAIT));
    e1 = ef || (!r0 && r1);
    e0 = r0 && !e1;
    ea = e0 ? a0 : (e1 ? a1 : last_addr);
    chk("gnt0", 32'(gnt0), 32'(e0));
    chk("gnt1", 32'(gnt1), 32'(e1));
    chk("rom_addr", 32'(rom_addr), 32'(ea));
    chk("forced", 32'(forced), 32'(prev_force));
    if (e0 || e1) begin
      item.due   = cyc_cnt + 1;
      item.owner = e1;
      item.addr  = ea;
      sbq.push_back(item);
    end
    last_addr  = ea;
    prev_force = ef;
    if (r1 && !e1) denied = (denied + 1 > int'(MAX_WAIT)) ? int'(MAX_WAIT) : denied + 1;
    else denied = 0;
  endtask

  // Monitor: pops a prediction whenever a word is delivered
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) continue;
      if (valid0 && valid1) chk("valid_both", 32'd1, 32'd0);
      if (valid0 || valid1) begin
        if (sbq.size() == 0) begin
          chk("unexpected_valid", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("valid_latency", 32'(cyc_cnt), 32'(e.due));
          chk("valid_owner", 32'(valid1), 32'(e.owner));
          if (e.owner) begin
            chk("data1", 32'(data1), 32'(rom_mem[e.addr]));
            last_d1 = rom_mem[e.addr];
          end else begin
            chk("data0", 32'(data0), 32'(rom_mem[e.addr]));
            last_d0 = rom_mem[e.addr];
          end
        end
      end else if (sbq.size() > 0 && sbq[0].due <= cyc_cnt) begin
        chk("missing_valid", 32'd0, 32'd1);
        void'(sbq.pop_front());
      end
      if (!valid0) chk("data0_hold", 32'(data0), 32'(last_d0));
      if (!valid1) chk("data1_hold", 32'(data1), 32'(last_d1));
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) rom_mem[i] = 8'($urandom);
    model_reset();
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
    #2;
    chk("rst_gnt0", 32'(gnt0), 32'd0);
    chk("rst_gnt1", 32'(gnt1), 32'd0);
    chk("rst_valid", 32'({valid0, valid1}), 32'd0);
    chk("rst_forced", 32'(forced), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_data", 32'({data0, data1}), 32'd0);
    // Request during reset must not be granted
    req0 = 1'b1; addr0 = 6'h3f;
    #1;
    chk("rst_gnt_blocked", 32'(gnt0), 32'd0);
    req0 = 1'b0;
    #3 reset = 1'b0;

    // Single read by requester 0
    cycle(1'b1, 6'h05, 1'b0, 6'h00);
    for (int i = 0; i < 3; i++) cycle(1'b0, 6'(i), 1'b0, 6'(i));

    // Sustained contention: forced grant every fifth cycle
    for (int i = 0; i < 15; i++) cycle(1'b1, 6'($urandom), 1'b1, 6'($urandom));
    cycle(1'b0, 6'h00, 1'b0, 6'h00);

    // Requester 1 alone, streaming addresses 10..13
    for (int i = 0; i < 4; i++) cycle(1'b0, 6'h00, 1'b1, 6'h10 + 6'(i));
    cycle(1'b0, 6'h00, 1'b0, 6'h00);

    // Denial streak broken by req1 dropping restarts the wait count
    for (int i = 0; i < 3; i++) cycle(1'b1, 6'h20 + 6'(i), 1'b1, 6'h30);
    cycle(1'b1, 6'h23, 1'b0, 6'h30);
    for (int i = 0; i < 6; i++) cycle(1'b1, 6'h24 + 6'(i), 1'b1, 6'h31);
    cycle(1'b0, 6'h00, 1'b0, 6'h00);

    // Asynchronous reset mid-cycle after a grant to requester 0
    cycle(1'b1, 6'h2a, 1'b0, 6'h00);
    #2;
    reset = 1'b1;
    req0  = 1'b0;
    #1;
    model_reset();
    chk("arst_gnt0", 32'(gnt0), 32'd0);
    chk("arst_valid0", 32'(valid0), 32'd0);
    chk("arst_data0", 32'(data0), 32'd0);
    chk("arst_rom_addr", 32'(rom_addr), 32'd0);
    chk("arst_forced", 32'(forced), 32'd0);
    #1 reset = 1'b0;
    for (int i = 0; i < 2; i++) cycle(1'b0, 6'h00, 1'b0, 6'h00);

    // Randomised traffic with varying request densities
    for (int i = 0; i < 3000; i++) begin
      int unsigned p0, p1;
      p0 = (i < 1500) ? 70 : 40;
      p1 = (i < 1500) ? 80 : 50;
      cycle(($urandom_range(99) < p0), 6'($urandom), ($urandom_range(99) < p1), 6'($urandom));
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 6'h00, 1'b0, 6'h00);
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
